// File: rtl/alu_instr_issuer.sv
// Purpose : queues ALU requests, issues them one at a time as 20-bit instruction
//           words to the control unit and returns captured results in order.
// Latency : cmd accepted in cycle N -> instruction in N+2 -> rsp_valid in N+3;
//           steady state one result every 2 cycles.
// Backpressure: cmd_ready drops when DEPTH commands are queued; a stalled
//           response (rsp_valid && !rsp_ready) holds all rsp_* and instruction.
//
// Ports:
//   clk, rst_n                    clock, synchronous active-low reset
//   cmd_valid/cmd_ready           request handshake; cmd_opcode, cmd_a, cmd_b payload
//   instruction                   {opcode, A, B} to the control unit
//   alu_out, alu_carry,
//   alu_overflow, alu_zero        combinational result of the current instruction
//   rsp_valid/rsp_ready           response handshake; rsp_data, rsp_flags
//                                 ({carry, overflow, zero}), rsp_opcode payload
//   fifo_count                    commands queued, excluding the one in flight
module alu_instr_issuer #(
   parameter int DEPTH = 4,
   parameter int CW    = $clog2(DEPTH) + 1
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          cmd_valid,
   output logic          cmd_ready,
   input  logic [3:0]    cmd_opcode,
   input  logic [7:0]    cmd_a,
   input  logic [7:0]    cmd_b,
   output logic [19:0]   instruction,
   input  logic [7:0]    alu_out,
   input  logic          alu_carry,
   input  logic          alu_overflow,
   input  logic          alu_zero,
   output logic          rsp_valid,
   input  logic          rsp_ready,
   output logic [7:0]    rsp_data,
   output logic [2:0]    rsp_flags,
   output logic [3:0]    rsp_opcode,
   output logic [CW-1:0] fifo_count
);

   localparam int            AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [CW-1:0] FULL_C = CW'(DEPTH);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_ISSUE   = 2'd1,
      S_RESPOND = 2'd2
   } state_t;

   state_t          r_state;
   state_t          w_state_nxt;

   logic [19:0]     r_mem [DEPTH];
   logic [AW-1:0]   r_wr_ptr;
   logic [AW-1:0]   r_rd_ptr;
   logic [CW-1:0]   r_count;

   logic [19:0]     r_instr;
   logic [7:0]      r_rsp_data;
   logic [2:0]      r_rsp_flags;
   logic [3:0]      r_rsp_opcode;

   logic            w_push;
   logic            w_pop;
   logic            w_capture;
   logic            w_empty;

   // Ready depends only on registered occupancy, so no combinational path
   // from cmd_valid or the response side reaches cmd_ready.
   assign cmd_ready = (r_count < FULL_C);
   assign w_push    = cmd_valid && cmd_ready;
   assign w_empty   = (r_count == '0);

   // Next-state / control decode
   always_comb begin
      w_state_nxt = r_state;
      w_pop       = 1'b0;
      w_capture   = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (!w_empty) begin
               w_pop       = 1'b1;
               w_state_nxt = S_ISSUE;
            end
         end
         S_ISSUE: begin
            // instruction has been stable for the whole cycle; sample the
            // control unit's combinational result at the closing edge
            w_capture   = 1'b1;
            w_state_nxt = S_RESPOND;
         end
         S_RESPOND: begin
            if (rsp_ready) begin
               if (!w_empty) begin
                  w_pop       = 1'b1;
                  w_state_nxt = S_ISSUE;
               end else begin
                  w_state_nxt = S_IDLE;
               end
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   // Queue storage carries no reset: entries are only read after being written.
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= {cmd_opcode, cmd_a, cmd_b};
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state      <= S_IDLE;
         r_wr_ptr     <= '0;
         r_rd_ptr     <= '0;
         r_count      <= '0;
         r_instr      <= '0;
         r_rsp_data   <= '0;
         r_rsp_flags  <= '0;
         r_rsp_opcode <= '0;
      end else begin
         r_state <= w_state_nxt;

         // Power-of-two depth: pointers wrap by natural overflow.
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + AW'(1);
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + AW'(1);
            r_instr  <= r_mem[r_rd_ptr];
         end

         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CW'(1);
            2'b01:   r_count <= r_count - CW'(1);
            default: r_count <= r_count;
         endcase

         if (w_capture) begin
            r_rsp_data   <= alu_out;
            r_rsp_flags  <= {alu_carry, alu_overflow, alu_zero};
            r_rsp_opcode <= r_instr[19:16];
         end
      end
   end

   assign instruction = r_instr;
   assign rsp_valid   = (r_state == S_RESPOND);
   assign rsp_data    = r_rsp_data;
   assign rsp_flags   = r_rsp_flags;
   assign rsp_opcode  = r_rsp_opcode;
   assign fifo_count  = r_count;

endmodule
